// File: rtl/lifo_arbiter.sv
// Two-requester round-robin front end for a shared lifo stack: depth tracking,
// strobe generation and one-cycle responses. Define LIFO_ARBITER_GUARD_EN to refuse illegal operations.
module lifo_arbiter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 12
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_a_valid,
  input  logic [1:0]                     i_a_op,
  input  logic [WIDTH-1:0]               i_a_data,
  output logic                           o_a_ready,
  input  logic                           i_b_valid,
  input  logic [1:0]                     i_b_op,
  input  logic [WIDTH-1:0]               i_b_data,
  output logic                           o_b_ready,
  output logic [WIDTH-1:0]               o_data,
  output logic                           o_push,
  output logic                           o_pop,
  output logic                           o_swap,
  input  logic [WIDTH-1:0]               i_s0,
  input  logic [WIDTH-1:0]               i_s1,
  output logic                           o_rsp_valid,
  output logic                           o_rsp_id,
  output logic                           o_rsp_err,
  output logic [WIDTH-1:0]               o_rsp_s0,
  output logic [WIDTH-1:0]               o_rsp_s1,
  output logic [$clog2(DEPTH+1)-1:0]     o_depth,
  output logic                           o_empty,
  output logic                           o_full
);

  localparam int            DW      = $clog2(DEPTH+1);
  localparam logic [DW-1:0] DEPTH_L = DW'(DEPTH);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_e;

  pri_e            pri_q, pri_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            gnt_a, gnt_b, gnt, issue;
  logic [1:0]      op_sel;
  logic [WIDTH-1:0] data_sel;
  logic            rsp_vld_p1, rsp_id_p1;

  // Depth step with saturation at both ends, so unchecked traffic cannot wrap.
  function automatic logic [DW-1:0] depth_step(input logic [1:0] op, input logic [DW-1:0] d);
    case (op)
      OP_PUSH: return (d == DEPTH_L) ? d : d + DW'(1);
      OP_POP:  return (d == '0)      ? d : d - DW'(1);
      default: return d;
    endcase
  endfunction

`ifdef LIFO_ARBITER_GUARD_EN
  logic legal;
  logic rsp_err_p1;

  function automatic logic op_legal(input logic [1:0] op, input logic [DW-1:0] d);
    case (op)
      OP_PUSH:         return d < DEPTH_L;
      OP_POP, OP_REPL: return d != '0;
      default:         return d >= DW'(2);
    endcase
  endfunction
`endif

  // Arbitration and next state
  always_comb begin
    pri_d    = pri_q;
    gnt_a    = i_a_valid && (!i_b_valid || (pri_q == PRI_A));
    gnt_b    = i_b_valid && !gnt_a;
    gnt      = gnt_a || gnt_b;
    op_sel   = gnt_b ? i_b_op   : i_a_op;
    data_sel = gnt_b ? i_b_data : i_a_data;
`ifdef LIFO_ARBITER_GUARD_EN
    legal    = op_legal(op_sel, depth_q);
    issue    = gnt && legal;
`else
    issue    = gnt;
`endif
    depth_d  = issue ? depth_step(op_sel, depth_q) : depth_q;
    if (gnt_a)
      pri_d = PRI_B;
    else if (gnt_b)
      pri_d = PRI_A;
  end

  // Strobes toward the lifo, live only in the grant cycle
  always_comb begin
    o_push = issue && ((op_sel == OP_PUSH) || (op_sel == OP_REPL));
    o_pop  = issue && ((op_sel == OP_POP)  || (op_sel == OP_REPL));
    o_swap = issue &&  (op_sel == OP_SWAP);
    o_data = o_push ? data_sel : '0;
  end

  assign o_a_ready = gnt_a;
  assign o_b_ready = gnt_b;

  // Stage p1: control state and response registered at the grant
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pri_q      <= PRI_A;
      depth_q    <= '0;
      rsp_vld_p1 <= 1'b0;
      rsp_id_p1  <= 1'b0;
    end else begin
      pri_q      <= pri_d;
      depth_q    <= depth_d;
      rsp_vld_p1 <= gnt;
      if (gnt)
        rsp_id_p1 <= gnt_b;
    end
  end

`ifdef LIFO_ARBITER_GUARD_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      rsp_err_p1 <= 1'b0;
    else if (gnt)
      rsp_err_p1 <= !legal;
  end
  assign o_rsp_err = rsp_err_p1;
`else
  assign o_rsp_err = 1'b0;
`endif

  assign o_rsp_valid = rsp_vld_p1;
  assign o_rsp_id    = rsp_id_p1;
  // The lifo has already applied the strobes, so its outputs are the post-op view.
  assign o_rsp_s0    = i_s0;
  assign o_rsp_s1    = i_s1;
  assign o_depth     = depth_q;
  assign o_empty     = (depth_q == '0);
  assign o_full      = (depth_q == DEPTH_L);

endmodule

// File: tb/tb_lifo_arbiter.sv
// Scoreboard bench for lifo_arbiter with a behavioural lifo attached to its strobes.
module tb_lifo_arbiter;
  localparam int W = 16;
`ifdef LIFO_ARBITER_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic i_clk = 1'b0, i_rst = 1'b1;
  logic i_a_valid = 0, i_b_valid = 0;
  logic [1:0] i_a_op = 0, i_b_op = 0;
  logic [W-1:0] i_a_data = 0, i_b_data = 0;
  logic o_a_ready, o_b_ready, o_push, o_pop, o_swap;
  logic [W-1:0] o_data, i_s0, i_s1, o_rsp_s0, o_rsp_s1;
  logic o_rsp_valid, o_rsp_id, o_rsp_err, o_empty, o_full;
  logic [3:0] o_depth;

  lifo_arbiter #(.WIDTH(W), .DEPTH(12)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_a_valid(i_a_valid), .i_a_op(i_a_op), .i_a_data(i_a_data), .o_a_ready(o_a_ready),
    .i_b_valid(i_b_valid), .i_b_op(i_b_op), .i_b_data(i_b_data), .o_b_ready(o_b_ready),
    .o_data(o_data), .o_push(o_push), .o_pop(o_pop), .o_swap(o_swap),
    .i_s0(i_s0), .i_s1(i_s1),
    .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_err(o_rsp_err),
    .o_rsp_s0(o_rsp_s0), .o_rsp_s1(o_rsp_s1),
    .o_depth(o_depth), .o_empty(o_empty), .o_full(o_full));

  always #5 i_clk = ~i_clk;

  // Behavioural lifo driven by the arbiter strobes
  logic [W-1:0] stk [0:31];
  int sp;
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sp <= 0;
    else if (o_push && o_pop) begin if (sp > 0) stk[sp-1] <= o_data; end
    else if (o_push) begin if (sp < 32) begin stk[sp] <= o_data; sp <= sp + 1; end end
    else if (o_pop) begin if (sp > 0) sp <= sp - 1; end
    else if (o_swap) begin
      if (sp > 1) begin stk[sp-1] <= stk[sp-2]; stk[sp-2] <= stk[sp-1]; end
    end
  end
  assign i_s0 = (sp > 0) ? stk[sp-1] : '0;
  assign i_s1 = (sp > 1) ? stk[sp-2] : '0;

  typedef struct {
    logic id; logic err; logic [W-1:0] s0; logic [W-1:0] s1; bit c0; bit c1;
  } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: handshake rules every cycle, responses against the scoreboard
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_a_ready && o_b_ready) chk("both_ready", 1, 0);
      if (o_a_ready && !i_a_valid) chk("a_ready_no_valid", 1, 0);
      if (o_b_ready && !i_b_valid) chk("b_ready_no_valid", 1, 0);
      if (o_rsp_valid) begin
        if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_id", 32'(o_rsp_id), 32'(e.id));
          chk("rsp_err", 32'(o_rsp_err), 32'(e.err));
          if (e.c0) chk("rsp_s0", 32'(o_rsp_s0), 32'(e.s0));
          if (e.c1) chk("rsp_s1", 32'(o_rsp_s1), 32'(e.s1));
        end
      end
    end
  end

  task automatic do_op(input bit who, input logic [1:0] op, input logic [W-1:0] d,
                       input logic [2:0] xstr, input logic [W-1:0] xdata, input logic xerr,
                       input logic [W-1:0] s0, input logic [W-1:0] s1, input bit c0, input bit c1);
    bit done = 0;
    exp_t e;
    if (who) begin i_b_valid = 1; i_b_op = op; i_b_data = d; end
    else     begin i_a_valid = 1; i_a_op = op; i_a_data = d; end
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge i_clk);
      if (who ? o_b_ready : o_a_ready) begin
        done = 1;
        chk("strobes", 32'({o_push, o_pop, o_swap}), 32'(xstr));
        chk("o_data", 32'(o_data), 32'(xdata));
        e = '{id: who, err: xerr, s0: s0, s1: s1, c0: c0, c1: c1};
        sb.push_back(e);
      end
    end
    if (!done) chk("grant_timeout", 0, 1);
    @(posedge i_clk);
    #1;
    i_a_valid = 0; i_b_valid = 0;
  endtask

  task automatic do_reset();
    i_rst = 1;
    #3;
    sb.delete();
    @(negedge i_clk);
    i_rst = 0;
    @(posedge i_clk);
    #1;
  endtask

  logic [W-1:0] ab_s0 [4] = '{16'd55, 16'd89, 16'd55, 16'd89};
  logic [W-1:0] ab_s1 [4] = '{16'd0,  16'd55, 16'd89, 16'd55};
  exp_t e;

  initial begin
    // Reset state while reset is held
    #12;
    chk("rst_depth", 32'(o_depth), 0);
    chk("rst_empty", 32'(o_empty), 1);
    chk("rst_full", 32'(o_full), 0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 0);
    @(negedge i_clk); i_rst = 0; @(posedge i_clk); #1;

    // Simple pushes from A
    do_op(0, 2'b00, 16'd13, 3'b100, 16'd13, 0, 16'd13, 0, 1, 0);
    do_op(0, 2'b00, 16'd21, 3'b100, 16'd21, 0, 16'd21, 16'd13, 1, 1);
    chk("depth_after_2push", 32'(o_depth), 2);

    // Both requesters pushing: grants alternate A, B, A, B
    do_reset();
    i_a_valid = 1; i_a_op = 2'b00; i_a_data = 16'd55;
    i_b_valid = 1; i_b_op = 2'b00; i_b_data = 16'd89;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      chk("ab_grant", 32'({o_b_ready, o_a_ready}), (k % 2) ? 2 : 1);
      e = '{id: 1'(k % 2), err: 0, s0: ab_s0[k], s1: ab_s1[k], c0: 1, c1: (k > 0)};
      sb.push_back(e);
      @(posedge i_clk);
    end
    #1; i_a_valid = 0; i_b_valid = 0;
    chk("depth_ab", 32'(o_depth), 4);

    // Stack bottom..top 55,89,55,89; swap then replace
    do_op(1, 2'b10, 16'd0, 3'b001, 16'd0, 0, 16'd55, 16'd89, 1, 1);
    chk("depth_swap", 32'(o_depth), 4);
    do_op(0, 2'b11, 16'd7, 3'b110, 16'd7, 0, 16'd7, 16'd89, 1, 1);
    chk("depth_repl", 32'(o_depth), 4);
    do_op(0, 2'b01, 16'd0, 3'b010, 16'd0, 0, 16'd89, 16'd89, 1, 1);
    do_op(1, 2'b01, 16'd0, 3'b010, 16'd0, 0, 16'd89, 16'd55, 1, 1);
    do_op(1, 2'b01, 16'd0, 3'b010, 16'd0, 0, 16'd55, 0, 1, 0);
    chk("depth_1", 32'(o_depth), 1);
    do_op(0, 2'b11, 16'd34, 3'b110, 16'd34, 0, 16'd34, 0, 1, 0);
    chk("depth_repl1", 32'(o_depth), 1);
    do_op(0, 2'b01, 16'd0, 3'b010, 16'd0, 0, 0, 0, 0, 0);
    chk("empty_after_pop", 32'(o_empty), 1);

    // Underflow: pop at depth 0
    do_op(0, 2'b01, 16'd0, GUARD ? 3'b000 : 3'b010, 16'd0, GUARD, 0, 0, 0, 0);
    chk("depth_underflow", 32'(o_depth), 0);

    // Swap at depth 1
    do_op(1, 2'b00, 16'd5, 3'b100, 16'd5, 0, 16'd5, 0, 1, 0);
    do_op(1, 2'b10, 16'd0, GUARD ? 3'b000 : 3'b001, 16'd0, GUARD, 16'd5, 0, 1, 0);
    chk("depth_swap1", 32'(o_depth), 1);

    // Fill to 12, then overflow push
    for (int k = 2; k <= 12; k++)
      do_op(0, 2'b00, 16'(100 + k), 3'b100, 16'(100 + k), 0, 16'(100 + k),
            (k == 2) ? 16'd5 : 16'(99 + k), 1, 1);
    chk("depth_full", 32'(o_depth), 12);
    chk("full_flag", 32'(o_full), 1);
    do_op(0, 2'b00, 16'd200, GUARD ? 3'b000 : 3'b100, GUARD ? 16'd0 : 16'd200, GUARD,
          GUARD ? 16'd112 : 16'd200, GUARD ? 16'd111 : 16'd112, 1, 1);
    chk("depth_overflow", 32'(o_depth), 12);
    chk("full_overflow", 32'(o_full), 1);

    // Asynchronous reset the cycle after a grant
    do_op(1, 2'b01, 16'd0, 3'b010, 16'd0, 0, 0, 0, 0, 0);
    chk("rsp_before_rst", 32'(o_rsp_valid), 1);
    #1 i_rst = 1;
    #1;
    chk("rst_rsp_drop", 32'(o_rsp_valid), 0);
    chk("rst_depth_async", 32'(o_depth), 0);
    chk("rst_empty_async", 32'(o_empty), 1);
    sb.delete();
    @(negedge i_clk); i_rst = 0; @(posedge i_clk); #1;
    i_a_valid = 1; i_a_op = 2'b00; i_a_data = 16'd55;
    i_b_valid = 1; i_b_op = 2'b00; i_b_data = 16'd89;
    @(negedge i_clk);
    chk("post_rst_grant", 32'({o_b_ready, o_a_ready}), 1);
    e = '{id: 0, err: 0, s0: 16'd55, s1: 0, c0: 1, c1: 0};
    sb.push_back(e);
    @(posedge i_clk); #1;
    i_a_valid = 0; i_b_valid = 0;

    repeat (3) @(posedge i_clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lifo_arbiter.md
Name: lifo_arbiter

Overview:
- Shares one `lifo` stack instance between two requesters, A and B, with a valid/ready handshake and round-robin arbitration.
- Translates each granted operation (push, pop, swap, replace) into one cycle of `lifo` control strobes.
- Tracks stack depth, guards against underflow and overflow, and returns a one-cycle response carrying the post-operation top-of-stack and next-on-stack.
- Sits between the `lifo` datapath and the sequencers that use it.

Parameters:
- WIDTH, 16: data width; must match the `lifo` WIDTH.
- DEPTH, 12: logical stack capacity in entries; sets the full threshold.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous reset, active-high
- i_a_valid  in  1  requester A has an operation
- i_a_op  in  2  A opcode: 00 push, 01 pop, 10 swap, 11 replace (pop+push)
- i_a_data  in  WIDTH  A push/replace data
- o_a_ready  out  1  A operation accepted this cycle
- i_b_valid, i_b_op, i_b_data, o_b_ready: identical set for requester B
- o_data  out  WIDTH  to `lifo` i_data
- o_push, o_pop, o_swap  out  1 each  to `lifo` strobes
- i_s0, i_s1  in  WIDTH each  from `lifo` o_s0 / o_s1
- o_rsp_valid  out  1  response pulse
- o_rsp_id  out  1  0 = A, 1 = B
- o_rsp_err  out  1  operation was refused
- o_rsp_s0, o_rsp_s1  out  WIDTH  post-operation TOS / NOS
- o_depth  out  $clog2(DEPTH+1)  current entry count
- o_empty, o_full  out  1  depth == 0 / depth == DEPTH

Behaviour:
- One clock domain (i_clk). i_rst is asynchronous and active-high.
- Reset state:
  - depth = 0, priority register = A, rsp_valid = 0, rsp_id = 0, rsp_err = 0.
  - o_empty = 1, o_full = 0.
  - `lifo` contents are not cleared; depth 0 defines the stack as logically empty.
  - Reset asserted mid-operation abandons any pending response.
- Arbitration (combinational, same cycle):
  - Only one valid requester: it is granted.
  - Both valid: the requester holding priority is granted.
  - Priority register flips to the non-granted requester on every grant.
  - At most one ready is high per cycle. A requester's ready is never high without its valid.
- Handshake:
  - An operation is consumed exactly when valid && ready.
  - Requesters hold op/data stable until ready.
  - Back-to-back grants are allowed every cycle; throughput is 1 operation per cycle.
- Strobe mapping, asserted in the grant cycle only, all low otherwise:
  - push: o_push = 1, o_data = requester data.
  - pop: o_pop = 1.
  - swap: o_swap = 1.
  - replace: o_pop = 1 and o_push = 1, o_data = requester data.
  - o_data = 0 when no push is issued.
- Legality (evaluated against the depth at the grant cycle):
  - push requires depth < DEPTH.
  - pop and replace require depth >= 1.
  - swap requires depth >= 2.
- Depth update on a legal grant, registered:
  - push: +1
  - pop: -1
  - swap, replace: unchanged
- Response:
  - o_rsp_valid pulses exactly one cycle after each grant.
  - o_rsp_id and o_rsp_err are registered at the grant.
  - o_rsp_s0 = i_s0 and o_rsp_s1 = i_s1 during the pulse; these are post-update `lifo` values.
  - Response values are meaningful only where depth permits: s0 when depth >= 1, s1 when depth >= 2.
- o_empty and o_full derive from registered depth.

Optional Feature:
- LIFO_ARBITER_GUARD_EN defined:
  - An illegal operation is still consumed (ready = 1).
  - No `lifo` strobe is issued and depth is unchanged.
  - The following response has o_rsp_err = 1.
- LIFO_ARBITER_GUARD_EN undefined:
  - All operations are forwarded to `lifo` unchecked.
  - Depth saturates at 0 and DEPTH.
  - o_rsp_err is tied to 0.

Test Plan:
- Reset, then A push 13, A push 21 -> o_push high in each grant cycle. Responses id 0: s0 = 13, then s0 = 21 / s1 = 13. o_depth = 2.
- A and B both valid every cycle, each pushing (A: 55, B: 89), priority = A after reset -> grants alternate A, B, A, B. o_rsp_id sequence 0, 1, 0, 1. Never both ready in one cycle.
- Depth 2 (TOS 89, NOS 55), B swap -> o_swap pulse. Response s0 = 55, s1 = 89. Depth stays 2.
- Depth 1 (TOS 34), A replace 7 -> o_pop and o_push in the same cycle, o_data = 7. Response s0 = 7. Depth stays 1.
- GUARD_EN, depth 0, A pop -> o_a_ready = 1, no strobes, o_rsp_err = 1, depth 0. Then depth 1, swap -> o_rsp_err = 1. Then push until depth 12, then push -> o_rsp_err = 1, o_full = 1.
- Assert i_rst asynchronously the cycle after a grant -> o_rsp_valid drops immediately, o_depth = 0, o_empty = 1. The next grant after release goes to A.
